// File: rtl/mas_div_pkg.sv
// rtl/mas_div_pkg.sv - shared widths and FSM states for the 64/32 restoring divider
package mas_div_pkg;

    localparam int DIVIDEND_W = 64;
    localparam int DIVISOR_W  = 32;
    localparam int STEPS      = 32;
    localparam int CNT_W      = 6;

    // {R[32:0], Q[31:0]} working register width
    localparam int RQ_W = DIVISOR_W + 1 + DIVISOR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/mas_div_restoring_step.sv
// rtl/mas_div_restoring_step.sv - one combinational restoring-division step on {R,Q}
import mas_div_pkg::*;

module mas_div_restoring_step (
    input  logic [RQ_W-1:0]      i_rq,
    input  logic [DIVISOR_W-1:0] i_d,
    output logic [RQ_W-1:0]      o_rq
);

    logic [RQ_W-1:0]    w_sh;
    logic [DIVISOR_W:0] w_t;

    assign w_sh = {i_rq[RQ_W-2:0], 1'b0};
    // R stays below D between steps, so the shifted R fits 33 bits and T[32] is a clean sign
    assign w_t  = w_sh[RQ_W-1:DIVISOR_W] - {1'b0, i_d};

    always_comb begin
        o_rq = w_sh;
        if (!w_t[DIVISOR_W]) begin
            o_rq = {w_t, w_sh[DIVISOR_W-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/mas_div_restoring_64x32.sv
// rtl/mas_div_restoring_64x32.sv - sequential 64/32 restoring divider; MAS_DIV_CHK_EN adds div-by-zero/overflow check
import mas_div_pkg::*;

module mas_div_restoring_64x32 (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVISOR_W-1:0]  quo,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  err
);

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [RQ_W-1:0]       r_rq;
    logic [DIVISOR_W-1:0]  r_d;
    logic                  r_busy;
    logic                  r_done;
    logic [DIVISOR_W-1:0]  r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [RQ_W-1:0]       w_rq_next;
    logic                  w_bad;

`ifdef MAS_DIV_CHK_EN
    logic r_err;
    logic r_ovf;

    // A quotient fits 32 bits only when the dividend's upper half is below the divisor
    assign w_bad = (divisor == '0) || (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor);
    assign err   = r_err;
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    mas_div_restoring_step u_step (
        .i_rq (r_rq),
        .i_d  (r_d),
        .o_rq (w_rq_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rq    <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
`ifdef MAS_DIV_CHK_EN
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rq    <= {1'b0, dividend};
                        r_d     <= divisor;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= w_bad ? FIN : CALC;
`ifdef MAS_DIV_CHK_EN
                        r_ovf   <= w_bad;
`endif
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                CALC: begin
                    r_rq  <= w_rq_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(STEPS - 1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    // busy stays high through the done cycle and drops on the following IDLE edge
                    r_done  <= 1'b1;
                    r_state <= IDLE;
`ifdef MAS_DIV_CHK_EN
                    if (r_ovf) begin
                        r_quo <= '1;
                        r_rem <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_quo <= r_rq[DIVISOR_W-1:0];
                        r_rem <= r_rq[RQ_W-2:DIVISOR_W];
                        r_err <= 1'b0;
                    end
`else
                    r_quo <= r_rq[DIVISOR_W-1:0];
                    r_rem <= r_rq[RQ_W-2:DIVISOR_W];
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quo  = r_quo;
    assign rem  = r_rem;

endmodule

// File: doc/mas_div_restoring_64x32.md
# mas_div_restoring_64x32

Sequential restoring divider, the inverse of the datapath's 32x32 multiplier. Divides a 64-bit unsigned dividend by a 32-bit unsigned divisor, producing a 32-bit quotient and a 32-bit remainder. It retires one quotient bit per clock behind a start/busy/done handshake. Sits beside the multiplier blocks in the arithmetic unit, so that mul/div results can be cross-checked (q*d + r == dividend).

## Interface
- No parameters; widths are fixed at 64/32.
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  64  unsigned dividend, captured at accept
- divisor  input  32  unsigned divisor, captured at accept
- busy  output  1  high in CALC and FIN
- done  output  1  one-cycle pulse; quo/rem/err are valid
- quo  output  32  quotient; held until the next accept
- rem  output  32  remainder; held until the next accept
- err  output  1  divide-by-zero or quotient overflow (only with MAS_DIV_CHK_EN; otherwise tied 0)

## Operation
- Reset is asynchronous and active-low on rstn, single clock clk.
- On reset: state=IDLE, busy=0, done=0, quo=0, rem=0, err=0, counter=0.
- States: IDLE, CALC, FIN.
- **IDLE -> CALC (accept):** taken when start=1.
  - Loads R (33 bit) = {1'b0, dividend[63:32]}, Q = dividend[31:0], D = divisor.
  - Loads counter = 0.
- **CALC:** each cycle performs one restoring step.
  - {R,Q} <<= 1.
  - T = R - {1'b0,D}.
  - If T is non-negative (T[32]==0): R = T and Q[0] = 1; otherwise R is kept and Q[0] = 0.
  - counter increments; after the 32nd step, go to FIN.
- **FIN:** quo=Q, rem=R[31:0], done=1 for exactly one cycle, then IDLE.
- start in CALC or FIN is ignored: no queueing, and operands are not re-sampled.
- Input operands may change freely after accept; only the captured copies are used.
- Reset asserted mid-operation aborts the operation. All outputs return to reset values and no done is issued.

## Timing
- Accept edge is T0.
- Steps execute on edges T1..T32.
- FIN occupies the cycle after T32, so done is high in the cycle following edge T33.
- Latency is 33 cycles from accept to done.
- busy rises the cycle after the accept edge and falls together with done.
- The next accept is possible at the earliest on the edge after done (the IDLE cycle). Throughput is one division per 34 cycles.
- quo, rem, err and done are all registered outputs; there is no combinational input-to-output path.

## Configuration
- MAS_DIV_CHK_EN defined:
  - At accept, if divisor==0 or dividend[63:32] >= divisor, go directly to FIN.
  - In that case: quo=32'hFFFF_FFFF, rem=0, err=1, with done in the cycle after the accept edge (latency 1).
  - Valid operands behave as in Operation, with err=0.
- MAS_DIV_CHK_EN undefined:
  - No check logic is built, and err is tied 0.
  - All operations take 33 cycles.
  - quo/rem for out-of-range operands are unspecified; the bench must not check them.

## Structure
- Package mas_div_pkg holds:
  - the state enum (IDLE, CALC, FIN);
  - localparams DIVIDEND_W=64, DIVISOR_W=32, STEPS=32, CNT_W=6.
- Sub-module mas_div_restoring_step (combinational).
  - Inputs: {R,Q} and D.
  - Outputs: the next {R,Q}.
  - Contains the shift and the 33-bit subtract and compare.
- The top level holds the FSM, counter, operand registers and output registers.

## Test plan
- 100 / 7 -> quo=14, rem=2, err=0; done exactly 33 cycles after accept; busy high for 34 cycles.
- 64'h0000_0001_0000_0000 / 2 -> quo=32'h8000_0000, rem=0.
- 64'hFFFF_FFFE_FFFF_FFFF / 32'hFFFF_FFFF -> quo=32'hFFFF_FFFF, rem=32'hFFFF_FFFE.
- With MAS_DIV_CHK_EN:
  - 64'h0000_0005_0000_0000 / 5 -> err=1, quo=32'hFFFF_FFFF, rem=0, done 1 cycle after accept.
  - divisor=0 -> same response.
- start held high across CALC and FIN with operands changing every cycle -> the first result is unaffected. The second accept occurs in the IDLE cycle after done and computes with the operands present on that edge.
- rstn pulsed low at step 10 of 1000/3 -> outputs go to 0 immediately and no done is issued. A following 1000/3 yields quo=333, rem=1.
